frame_transmitter: RTL and testbench
====================================

// Module: frame_transmitter
// PURPOSE
//  Serial frame transmitter. Pairs with the frame receiver that checks the stop bit.
//  Accepts a parallel word over a valid/ready handshake and serialises it on one line:
//  start bit (0), DATA_BITS data bits LSB first, then STOP_BITS stop bits (1).
//  Each bit is held for CLKS_PER_BIT clocks.
//  tx_start marks the first start-bit cycle and can drive a receiver's rx_start in loopback.
// PARAMETERS
//  DATA_BITS     3  data bits per frame (>=2); default gives a 5-bit frame with 1 stop bit
//  CLKS_PER_BIT  5  clocks each bit is held (>=1)
//  STOP_BITS     1  stop bits per frame (1 or 2)
// PORTS
//  clk                input   1          single clock, all logic on rising edge
//  reset              input   1          synchronous, active-high reset
//  tx_valid           input   1          word available on tx_data
//  tx_data            input   DATA_BITS  word to send, sampled only at handshake
//  force_frame_error  input   1          sampled at handshake; 1 = send stop bit(s) as 0
//  tx_ready           output  1          transmitter can accept a word
//  tx_start           output  1          1-cycle pulse in first cycle of start bit
//  data_out           output  1          serial line, idle high
//  tx_busy            output  1          frame in progress (START/DATA/STOP)
//  tx_done            output  1          1-cycle pulse after last stop-bit cycle
// BEHAVIOUR
//  - Reset (sync, high) is evaluated at the clock edge. Next cycle: state=IDLE, data_out=1,
//    tx_busy=0, tx_start=0, tx_done=0, counters=0.
//    tx_ready = (state==IDLE) & ~reset, so it is 0 while reset is high.
//  - Handshake is tx_valid & tx_ready at a rising edge. On it, tx_data and force_frame_error
//    are latched into the shift register, and the FSM goes IDLE->START.
//    tx_valid is ignored when tx_ready=0. tx_data changes after handshake have no effect.
//  - FSM states: IDLE, START, DATA, STOP.
//    * IDLE: line=1. Handshake -> START.
//    * START: line=0 for CLKS_PER_BIT cycles -> DATA.
//    * DATA: line=shreg[0]. Shift right after every CLKS_PER_BIT cycles.
//      After DATA_BITS bits -> STOP.
//    * STOP: line = ~err_latched for STOP_BITS*CLKS_PER_BIT cycles -> IDLE.
//  - clk_count counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//    bit_count counts the bits sent in DATA (and stop bits sent in STOP) and clears on each
//    state change. Counter widths are $clog2 of the maximum count +1.
//  - All outputs are registered except tx_ready.
//  - Latency: handshake at edge k. Start bit occupies cycles k+1..k+CLKS_PER_BIT.
//    The frame lasts (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
//    tx_done=1 and tx_ready=1 in the following cycle (IDLE, line=1).
//  - Back-to-back: a handshake in the tx_done cycle is legal. There is exactly 1 idle-high
//    cycle between frames.
//  - Reset mid-frame aborts the frame: line returns to 1 next cycle and tx_done is not
//    pulsed. The latched word is discarded.
//  - Reset coincident with tx_valid: reset wins and no word is accepted.
//  - CLKS_PER_BIT=1: the bit boundary occurs every cycle, so the counter is effectively
//    constant 0.
// STRUCTURE
//  - Shared package frame_pkg: state encodings (IDLE/START/DATA/STOP), LINE_IDLE=1'b1,
//    START_LEVEL=1'b0, STOP_LEVEL=1'b1. The receiver shares these constants.
//  - Sub-module frame_tx_shifter: DATA_BITS-wide, parallel load, shift right on shift_en,
//    serial out = bit 0.
//  - Counters and FSM are inline.
// TESTING (defaults unless noted; handshake edge = cycle 0)
//  1. tx_data=3'b101 -> data_out levels per cycle: c1-5=0, c6-10=1, c11-15=0, c16-20=1,
//     c21-25=1. tx_start=1 at c1 only. tx_done=1 and tx_ready=1 at c26.
//  2. tx_data=3'b011, force_frame_error=1 -> c21-25 data_out=0.
//     Looped into the receiver (tx_start->rx_start): frame_error asserts.
//     Repeat with force=0: no frame_error.
//  3. tx_valid held high with 3'b001 then 3'b110 -> second handshake at c26.
//     data_out=1 at c26; second start bit at c27-31. Receiver captures both words in order.
//  4. reset=1 at c12 -> c13: data_out=1, tx_busy=0, tx_ready=1. No tx_done pulse.
//     The next frame after this is bit-exact.
//  5. While busy, toggle tx_valid and tx_data=3'b111 -> tx_ready=0 throughout.
//     The transmitted frame still carries the originally latched word.
//  6. DATA_BITS=8, CLKS_PER_BIT=1, STOP_BITS=2, tx_data=8'hA5 -> data_out c1..c11 =
//     0,1,0,1,0,0,1,0,1,1,1. tx_done at c12.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame-line constants and transmitter state encoding; the receiver imports the same package.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } frame_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/frame_tx_shifter.sv
// Parallel-load, shift-right register feeding the serial line LSB first.
module frame_tx_shifter
  import frame_pkg::*;
#(
  parameter int DATA_BITS = 3
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 serial_out,
  output logic                 serial_next
);

  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (load)
      shreg <= din;
    else if (shift_en)
      shreg <= {1'b0, shreg[DATA_BITS-1:1]};
  end

  assign serial_out  = shreg[0];
  // Bit that reaches position 0 after the next shift; lets the line register look ahead.
  assign serial_next = shreg[1];

endmodule

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: start bit, LSB-first data, stop bit(s), each held CLKS_PER_BIT clocks.
module frame_transmitter
  import frame_pkg::*;
#(
  parameter int DATA_BITS    = 3,
  parameter int CLKS_PER_BIT = 5,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 force_frame_error,
  output logic                 tx_ready,
  output logic                 tx_start,
  output logic                 data_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  frame_state_e  state, state_next;
  logic [CW-1:0] clk_count, clk_count_next;
  logic [BW-1:0] bit_count, bit_count_next;
  logic          err_latched;
  logic          load, shift_en, bit_end;
  logic          line_next, start_next, done_next;
  logic          serial_bit, next_bit;

  assign tx_ready = (state == IDLE) & ~reset;
  assign load     = tx_valid & tx_ready;
  assign bit_end  = (clk_count == CW'(CLKS_PER_BIT - 1));

  frame_tx_shifter #(
    .DATA_BITS (DATA_BITS)
  ) u_shifter (
    .clk         (clk),
    .load        (load),
    .shift_en    (shift_en),
    .din         (tx_data),
    .serial_out  (serial_bit),
    .serial_next (next_bit)
  );

  always_comb begin
    state_next     = state;
    clk_count_next = clk_count;
    bit_count_next = bit_count;
    shift_en       = 1'b0;
    start_next     = 1'b0;
    done_next      = 1'b0;
    line_next      = LINE_IDLE;

    unique case (state)
      IDLE: begin
        if (load) begin
          state_next = START;
          start_next = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next     = DATA;
          clk_count_next = '0;
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_count_next = '0;
          shift_en       = 1'b1;
          if (bit_count == BW'(DATA_BITS - 1)) begin
            state_next     = STOP;
            bit_count_next = '0;
          end else begin
            bit_count_next = bit_count + 1'b1;
          end
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_count_next = '0;
          if (bit_count == BW'(STOP_BITS - 1)) begin
            state_next     = IDLE;
            bit_count_next = '0;
            done_next      = 1'b1;
          end else begin
            bit_count_next = bit_count + 1'b1;
          end
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      default: ;
    endcase

    // The line is registered, so it is driven from where the FSM will be next cycle.
    unique case (state_next)
      IDLE:    line_next = LINE_IDLE;
      START:   line_next = START_LEVEL;
      DATA:    line_next = shift_en ? next_bit : serial_bit;
      STOP:    line_next = err_latched ? ~STOP_LEVEL : STOP_LEVEL;
      default: line_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_count <= '0;
      data_out  <= LINE_IDLE;
      tx_start  <= 1'b0;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_next;
      clk_count <= clk_count_next;
      bit_count <= bit_count_next;
      data_out  <= line_next;
      tx_start  <= start_next;
      tx_done   <= done_next;
      tx_busy   <= (state_next != IDLE);
    end
  end

  // Stale error flag after an aborted frame is harmless: it is reloaded at every handshake.
  always_ff @(posedge clk) begin
    if (load)
      err_latched <= force_frame_error;
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// Bench for frame_transmitter: per-cycle timeline model, table of frames, corner sequences.
module tb_frame_transmitter;

  localparam int DB  = 3;
  localparam int CPB = 5;
  localparam int SB  = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid = 1'b0;
  logic [2:0] tx_data = '0;
  logic force_err = 1'b0;
  logic tx_ready, tx_start, data_out, tx_busy, tx_done;

  logic b_valid = 1'b0;
  logic [7:0] b_data = '0;
  logic b_ready, b_start, b_out, b_busy, b_done;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  frame_transmitter #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk (clk), .reset (reset), .tx_valid (tx_valid), .tx_data (tx_data),
    .force_frame_error (force_err), .tx_ready (tx_ready), .tx_start (tx_start),
    .data_out (data_out), .tx_busy (tx_busy), .tx_done (tx_done)
  );

  frame_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk (clk), .reset (reset), .tx_valid (b_valid), .tx_data (b_data),
    .force_frame_error (1'b0), .tx_ready (b_ready), .tx_start (b_start),
    .data_out (b_out), .tx_busy (b_busy), .tx_done (b_done)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // Reference model: each accepted word expands into a queue of per-cycle expectations.
  typedef struct packed {
    logic line;
    logic start;
    logic busy;
    logic done;
  } exp_t;

  exp_t mq[$];
  exp_t cur = exp_t'{1'b1, 1'b0, 1'b0, 1'b0};
  bit   m_hs = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    logic lvl;
    m_hs = 1'b0;
    if (reset) begin
      mq.delete();
    end else if (mq.size() == 0 && tx_valid) begin
      m_hs = 1'b1;
      for (int s = 0; s < 1 + DB + SB; s++) begin
        if (s == 0)       lvl = 1'b0;
        else if (s <= DB) lvl = tx_data[s-1];
        else              lvl = ~force_err;
        for (int k = 0; k < CPB; k++) begin
          e = exp_t'{lvl, (s == 0 && k == 0), 1'b1, 1'b0};
          mq.push_back(e);
        end
      end
      e = exp_t'{1'b1, 1'b0, 1'b0, 1'b1};
      mq.push_back(e);
    end
    if (mq.size() > 0) cur = mq.pop_front();
    else               cur = exp_t'{1'b1, 1'b0, 1'b0, 1'b0};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon data_out", data_out, cur.line);
      chk("mon tx_start", tx_start, cur.start);
      chk("mon tx_busy",  tx_busy,  cur.busy);
      chk("mon tx_done",  tx_done,  cur.done);
      chk("mon tx_ready", tx_ready, (mq.size() == 0) && !reset);
    end
  end

  // Call away from posedge; returns 2 time units after the handshake edge (cycle 1).
  task automatic send(input logic [2:0] d, input logic e);
    int n = 0;
    tx_data   = d;
    force_err = e;
    tx_valid  = 1'b1;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!m_hs && n < 200);
    tx_valid = 1'b0;
    if (!m_hs) begin
      total++;
      bad++;
      $display("FAIL handshake timeout: got none want accept of %b", d);
    end
  endtask

  typedef struct {
    logic [2:0] data;
    logic       err;
    logic [4:0] levels;   // bit s = line level during bit slot s (start, d0..d2, stop)
  } vec_t;

  task automatic check_frame(input vec_t v);
    send(v.data, v.err);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c <= 25 && (c - 1) % 5 == 2) chk("table slot level", data_out, v.levels[(c-1)/5]);
      if (c == 1)  chk("table tx_start c1", tx_start, 1'b1);
      if (c == 2)  chk("table tx_start c2", tx_start, 1'b0);
      if (c == 25) chk("table tx_done c25", tx_done, 1'b0);
      if (c == 26) begin
        chk("table tx_done c26", tx_done, 1'b1);
        chk("table tx_ready c26", tx_ready, 1'b1);
        chk("table idle line c26", data_out, 1'b1);
      end
    end
  endtask

  vec_t vecs[6];
  logic [10:0] exp6;

  initial begin
    vecs[0] = '{3'b101, 1'b0, 5'b11010};
    vecs[1] = '{3'b011, 1'b1, 5'b00110};
    vecs[2] = '{3'b011, 1'b0, 5'b10110};
    vecs[3] = '{3'b000, 1'b0, 5'b10000};
    vecs[4] = '{3'b111, 1'b1, 5'b01110};
    vecs[5] = '{3'b100, 1'b0, 5'b11000};
    exp6    = 11'b11101001010;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset data_out", data_out, 1'b1);
    chk("reset tx_busy",  tx_busy,  1'b0);
    chk("reset tx_start", tx_start, 1'b0);
    chk("reset tx_done",  tx_done,  1'b0);
    chk("reset tx_ready", tx_ready, 1'b0);
    chk("reset b_ready",  b_ready,  1'b0);
    reset = 1'b0;
    #1;
    chk("post-reset tx_ready", tx_ready, 1'b1);
    mon_en = 1'b1;

    // Wide frame, one clock per bit, two stop bits
    b_data  = 8'hA5;
    b_valid = 1'b1;
    @(posedge clk); #2;
    b_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 11) chk("wide line", b_out, exp6[c-1]);
      if (c == 1)  chk("wide tx_start", b_start, 1'b1);
      if (c == 11) chk("wide tx_done c11", b_done, 1'b0);
      if (c == 12) begin
        chk("wide tx_done c12", b_done, 1'b1);
        chk("wide tx_ready c12", b_ready, 1'b1);
      end
    end

    // Table of frames
    for (int i = 0; i < 6; i++) check_frame(vecs[i]);

    // Back-to-back with tx_valid held high
    send(3'b001, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 3'b110;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 26) begin
        chk("b2b idle line c26", data_out, 1'b1);
        chk("b2b tx_done c26", tx_done, 1'b1);
      end
      if (c == 27) begin
        chk("b2b start line c27", data_out, 1'b0);
        chk("b2b tx_start c27", tx_start, 1'b1);
      end
    end
    tx_valid = 1'b0;
    repeat (26) @(negedge clk);

    // Reset mid-frame
    send(3'b101, 1'b0);
    repeat (12) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("reset-held tx_ready", tx_ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort data_out", data_out, 1'b1);
    chk("abort tx_busy", tx_busy, 1'b0);
    chk("abort tx_ready", tx_ready, 1'b1);
    chk("abort tx_done", tx_done, 1'b0);
    check_frame(vecs[0]);

    // Reset coincident with tx_valid
    @(posedge clk); #2;
    reset = 1'b1; tx_valid = 1'b1; tx_data = 3'b111;
    @(posedge clk); #2;
    reset = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    chk("reset+valid tx_busy", tx_busy, 1'b0);
    chk("reset+valid data_out", data_out, 1'b1);

    // Input activity while busy
    send(3'b010, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      chk("busy tx_ready", tx_ready, 1'b0);
      #1;
      tx_valid = (c % 2 == 1);
      tx_data  = 3'b111;
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      tx_valid  = ($urandom_range(0, 1) == 1);
      tx_data   = 3'($urandom);
      force_err = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #2;
    reset = 1'b0; tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
